// File: rtl/time_set_ctrl.sv
// time_set_ctrl -- front-panel time-setting controller.
//
// Two buttons (mode, inc) are debounced independently. A mode press walks
// the FSM RUN -> SET_HR -> SET_MIN -> COMMIT -> RUN. Entering SET_HR snapshots
// the running time into shadow registers. The inc button edits those registers
// in BCD. COMMIT issues a one-cycle load strobe back to the time counter.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   btn_mode, btn_inc     synchronized raw button levels
//   tick                  1 Hz pulse; drives the edit-digit blink only
//   cur_hour, cur_min     running time, BCD {tens,ones}
//   count_en              time counter enable (low while editing)
//   load                  one-cycle load strobe, high only in COMMIT
//   load_hour, load_min   shadow time, BCD
//   blank                 per-digit blank mask, bit0=sec ones .. bit5=hour tens
//   mode                  FSM state encoding

// Single-button debouncer. The level flips after DB_CYCLES consecutive
// samples that disagree with it. A rising flip emits a registered press.
module time_set_ctrl_db #(
  parameter int DB_CYCLES = 16,
  parameter int INC_WIDTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  logic [INC_WIDTH-1:0] cnt;
  logic                 level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == INC_WIDTH'(DB_CYCLES - 1)) begin
        // This sample is the DB_CYCLES-th consecutive disagreement.
        level <= raw;
        cnt   <= '0;
        press <= raw;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module time_set_ctrl #(
  parameter int DB_CYCLES = 16,
  parameter int INC_WIDTH = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  output logic       count_en,
  output logic       load,
  output logic [7:0] load_hour,
  output logic [7:0] load_min,
  output logic [5:0] blank,
  output logic [1:0] mode
);
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    COMMIT  = 2'b11
  } state_t;

  localparam int NUM_BTN = 2;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_press;
  logic               press_mode, press_inc;

  assign btn_raw    = {btn_inc, btn_mode};
  assign press_mode = btn_press[0];
  assign press_inc  = btn_press[1];

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
    time_set_ctrl_db #(
      .DB_CYCLES(DB_CYCLES),
      .INC_WIDTH(INC_WIDTH)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[b]),
      .press(btn_press[b])
    );
  end

  function automatic logic hour_ok(input logic [7:0] h);
    return (h[7:4] == 4'd0 && h[3:0] <= 4'd9) ||
           (h[7:4] == 4'd1 && h[3:0] <= 4'd1);
  endfunction

  function automatic logic min_ok(input logic [7:0] m);
    return (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9);
  endfunction

  // Shadow values are always valid BCD, so only the 11 and x9 cases matter.
  function automatic logic [7:0] hour_inc(input logic [7:0] h);
    if (h == 8'h11)           return 8'h00;
    else if (h[3:0] == 4'd9)  return {h[7:4] + 4'd1, 4'd0};
    else                      return {h[7:4], h[3:0] + 4'd1};
  endfunction

  // Minute wraps 59->00 on its own; no carry into the hour.
  function automatic logic [7:0] min_inc(input logic [7:0] m);
    if (m[3:0] == 4'd9) begin
      if (m[7:4] == 4'd5) return 8'h00;
      else                return {m[7:4] + 4'd1, 4'd0};
    end
    return {m[7:4], m[3:0] + 4'd1};
  endfunction

  state_t     state, state_n;
  logic [7:0] sh_hour, sh_hour_n;
  logic [7:0] sh_min, sh_min_n;
  logic       blink_phase, blink_phase_n;
  logic [5:0] blank_n;

  always_comb begin
    state_n       = state;
    sh_hour_n     = sh_hour;
    sh_min_n      = sh_min;
    blink_phase_n = blink_phase;
    case (state)
      RUN: begin
        if (press_mode) begin
          state_n       = SET_HR;
          sh_hour_n     = hour_ok(cur_hour) ? cur_hour : 8'h00;
          sh_min_n      = min_ok(cur_min)   ? cur_min  : 8'h00;
          blink_phase_n = 1'b0;
        end
      end
      SET_HR: begin
        if (tick) blink_phase_n = ~blink_phase;
        if (press_mode)     state_n   = SET_MIN;
        else if (press_inc) sh_hour_n = hour_inc(sh_hour);
      end
      SET_MIN: begin
        if (tick) blink_phase_n = ~blink_phase;
        if (press_mode)     state_n  = COMMIT;
        else if (press_inc) sh_min_n = min_inc(sh_min);
      end
      COMMIT: state_n = RUN;  // presses seen here are dropped
      default: state_n = RUN;
    endcase
  end

  // Outputs are registered from next-state so they line up with mode.
  always_comb begin
    blank_n = 6'b000000;
    case (state_n)
      SET_HR:  blank_n = {blink_phase_n, blink_phase_n, 4'b0000};
      SET_MIN: blank_n = {2'b00, blink_phase_n, blink_phase_n, 2'b00};
      default: blank_n = 6'b000000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      sh_hour     <= 8'h00;
      sh_min      <= 8'h00;
      blink_phase <= 1'b0;
      count_en    <= 1'b1;
      load        <= 1'b0;
      blank       <= 6'b000000;
    end else begin
      state       <= state_n;
      sh_hour     <= sh_hour_n;
      sh_min      <= sh_min_n;
      blink_phase <= blink_phase_n;
      count_en    <= (state_n == RUN);
      load        <= (state_n == COMMIT);
      blank       <= blank_n;
    end
  end

  assign mode      = state;
  assign load_hour = sh_hour;
  assign load_min  = sh_min;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a behavioural model pushes the expected
// visible state after each stimulus step; the step result is popped and
// compared against the DUT outputs.
module tb_time_set_ctrl;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, tick;
  logic [7:0] cur_hour, cur_min;
  logic       count_en, load;
  logic [7:0] load_hour, load_min;
  logic [5:0] blank;
  logic [1:0] mode;

  time_set_ctrl #(.DB_CYCLES(DB), .INC_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .tick(tick), .cur_hour(cur_hour), .cur_min(cur_min),
    .count_en(count_en), .load(load), .load_hour(load_hour),
    .load_min(load_min), .blank(blank), .mode(mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int exp_load_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Every load pulse must come from COMMIT with the counter stopped.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt++;
      check("load_in_commit", 32'(mode), 32'd3);
      check("load_count_en", 32'(count_en), 32'd0);
    end
  end

  // Model
  int m_mode, m_hr, m_min;
  bit m_phase;

  function automatic int bcd2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction
  function automatic logic [7:0] i2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  typedef struct {
    string      tag;
    logic [1:0] mode;
    logic       ce;
    logic [7:0] hr, mn;
    logic [5:0] blank;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag  = tag;
    e.mode = 2'(m_mode);
    e.ce   = (m_mode == 0);
    e.hr   = i2bcd(m_hr);
    e.mn   = i2bcd(m_min);
    e.blank = (m_mode == 1) ? {m_phase, m_phase, 4'b0} :
              (m_mode == 2) ? {2'b0, m_phase, m_phase, 2'b0} : 6'b0;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_mode"}, 32'(mode), 32'(e.mode));
    check({e.tag, "_ce"}, 32'(count_en), 32'(e.ce));
    check({e.tag, "_hr"}, 32'(load_hour), 32'(e.hr));
    check({e.tag, "_min"}, 32'(load_min), 32'(e.mn));
    check({e.tag, "_blank"}, 32'(blank), 32'(e.blank));
    check({e.tag, "_load"}, 32'(load), 32'd0);
  endtask

  function automatic bit valid_bcd(input logic [7:0] b, input int maxv);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (bcd2i(b) <= maxv);
  endfunction

  task automatic model_press(input bit m, input bit i);
    case (m_mode)
      0: if (m) begin
           m_mode  = 1;
           m_hr    = valid_bcd(cur_hour, 11) ? bcd2i(cur_hour) : 0;
           m_min   = valid_bcd(cur_min, 59)  ? bcd2i(cur_min)  : 0;
           m_phase = 0;
         end
      1: if (m) m_mode = 2; else if (i) m_hr = (m_hr + 1) % 12;
      2: if (m) begin m_mode = 0; exp_load_cnt++; end
         else if (i) m_min = (m_min + 1) % 60;
      default: ;
    endcase
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Hold long enough to debounce the press, then long enough for release.
  task automatic press(input bit m, input bit i, input string tag);
    btn_mode = m; btn_inc = i;
    step(DB + 3);
    btn_mode = 0; btn_inc = 0;
    step(DB + 3);
    model_press(m, i);
    push_exp(tag);
    pop_check();
  endtask

  task automatic do_tick(input string tag);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    if (m_mode == 1 || m_mode == 2) m_phase = ~m_phase;
    push_exp(tag);
    pop_check();
  endtask

  initial begin
    reset = 1'b1; btn_mode = 0; btn_inc = 0; tick = 0;
    cur_hour = 8'h10; cur_min = 8'h58;
    m_mode = 0; m_hr = 0; m_min = 0; m_phase = 0;
    step(3);
    push_exp("reset"); pop_check();
    reset = 1'b0;
    step(2);

    // Glitch one sample short of the debounce threshold.
    btn_mode = 1; step(DB - 1); btn_mode = 0; step(DB + 2);
    push_exp("short_glitch"); pop_check();

    press(0, 1, "inc_in_run");
    do_tick("tick_in_run");

    press(1, 0, "enter_set_hr");
    press(0, 1, "hr_10_11");
    press(0, 1, "hr_11_00");
    do_tick("blink_on");
    do_tick("blink_off");
    press(1, 1, "mode_beats_inc");
    press(0, 1, "min_58_59");
    press(0, 1, "min_59_00");
    do_tick("blink_min");
    press(1, 0, "commit");
    check("load_count_1", 32'(load_cnt), 32'(exp_load_cnt));

    // Out-of-range capture falls back to 00.
    cur_hour = 8'h13; cur_min = 8'h5A;
    press(1, 0, "bad_capture");
    press(1, 0, "bad_to_min");
    press(1, 0, "bad_commit");

    cur_hour = 8'h09; cur_min = 8'h09;
    press(1, 0, "cap_0909");
    press(0, 1, "hr_09_10");
    press(1, 0, "to_min");
    press(0, 1, "min_09_10");

    // Abandon the edit with reset; no load may follow.
    reset = 1'b1;
    #1;
    m_mode = 0; m_hr = 0; m_min = 0; m_phase = 0;
    push_exp("reset_mid_edit"); pop_check();
    step(2);
    reset = 1'b0;
    step(DB * 3);
    push_exp("after_reset"); pop_check();
    check("load_count_final", 32'(load_cnt), 32'(exp_load_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16: consecutive clk samples a button must differ from its debounced level before that level changes.
REQ-002 SHALL have parameter INC_WIDTH, default 5: width of each debounce counter, sized to hold DB_CYCLES.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-005 SHALL have port btn_mode, input, 1: synchronized raw mode-button level.
REQ-006 SHALL have port btn_inc, input, 1: synchronized raw increment-button level.
REQ-007 SHALL have port tick, input, 1: one-cycle 1 Hz timekeeping pulse.
REQ-008 SHALL have port cur_hour, input, 8: current hour, BCD {tens,ones}.
REQ-009 SHALL have port cur_min, input, 8: current minute, BCD {tens,ones}.
REQ-010 SHALL have port count_en, output, 1: enable for the time counter.
REQ-011 SHALL have port load, output, 1: one-cycle load strobe for the time counter.
REQ-012 SHALL have port load_hour, output, 8: shadow hour in BCD.
REQ-013 SHALL have port load_min, output, 8: shadow minute in BCD.
REQ-014 SHALL have port blank, output, 6: per-digit blank mask; bit0=sec ones through bit5=hour tens.
REQ-015 SHALL have port mode, output, 2: current FSM state encoding.

Function
REQ-016 Each button SHALL have an independent debouncer: counter increments while raw differs from the debounced level and clears when they match.
REQ-017 When a debounce counter reaches DB_CYCLES, the debounced level SHALL toggle and the counter SHALL clear.
REQ-018 A 0->1 toggle of a debounced level SHALL produce a registered press pulse one cycle wide; 1->0 toggles SHALL produce no pulse.
REQ-019 The FSM SHALL have states RUN=00, SET_HR=01, SET_MIN=10, COMMIT=11, and mode SHALL equal the state.
REQ-020 In RUN: count_en=1 and blank=000000.
REQ-021 In RUN, a mode press SHALL move to SET_HR and capture cur_hour/cur_min into the shadow registers on the same edge.
REQ-022 In RUN, an inc press SHALL be ignored.
REQ-023 On capture, an hour that is not valid BCD in 00..11 SHALL be captured as 00.
REQ-024 On capture, a minute that is not valid BCD in 00..59 SHALL be captured as 00.
REQ-025 In SET_HR: count_en=0; an inc press SHALL add 1 to the shadow hour in BCD, wrapping 11->00; a mode press SHALL move to SET_MIN.
REQ-026 In SET_MIN: count_en=0; an inc press SHALL add 1 to the shadow minute in BCD (09->10, 59->00) with no carry into the hour; a mode press SHALL move to COMMIT.
REQ-027 In COMMIT: count_en=0 and load=1 for exactly that one cycle, then the FSM SHALL go unconditionally to RUN.
REQ-028 A press arriving while in COMMIT SHALL be discarded.
REQ-029 load SHALL be 0 in every state other than COMMIT.
REQ-030 load_hour and load_min SHALL continuously drive the shadow registers.
REQ-031 If mode and inc presses occur in the same cycle, mode SHALL win and inc SHALL be discarded.
REQ-032 blink_phase SHALL clear on entry to SET_HR and toggle on each tick while in SET_HR or SET_MIN.
REQ-033 blank[5:4] SHALL equal {blink_phase,blink_phase} in SET_HR and blank[3:2] SHALL equal them in SET_MIN; all other blank bits SHALL be 0.
REQ-034 tick SHALL have no effect on the shadow registers or the FSM.

Reset
REQ-035 Reset SHALL force state=RUN, count_en=1, load=0, blank=000000, mode=00, shadow hour and minute=00, blink_phase=0, both debounced levels=0, and both debounce counters=0.
REQ-036 Reset asserted mid-edit SHALL abandon the edit and produce no load pulse.

Verification
REQ-037 Reset released, btn_mode high for DB_CYCLES-1 cycles then low -> no press, mode=00, count_en=1.
REQ-038 cur_hour=0x10, cur_min=0x58, mode press -> mode=01, count_en=0; inc x2 -> load_hour=0x00 (11 wrapped to 00).
REQ-039 In SET_MIN with shadow 0x59, inc -> load_min=0x00 and load_hour unchanged; mode -> one cycle with load=1, mode=11, then mode=00, count_en=1.
REQ-040 In SET_HR, two ticks -> blank toggles 110000 then 000000; blank[3:0]=0000 throughout.
REQ-041 Simultaneous mode and inc debounced presses in SET_HR -> mode=10 and shadow hour unchanged.
REQ-042 Reset asserted in SET_MIN -> immediately mode=00, count_en=1, load never asserted, shadow=00/00.
